simd_divider: RTL and testbench

Iterative SIMD unsigned restoring divider. It is the inverse companion to the SIMD Booth multiplier datapath and shares that datapath's `mode` lane encoding and 16-bit operand / 32-bit result packing. One 16-bit, two 8-bit, or four 4-bit lanes are divided in parallel, one quotient bit per lane per clock. A start/busy/done handshake is included so the block can sit beside the multiplier behind the same issue logic.

---
 rtl/simd_divider.sv | 248 ++++++++++++++++++++++++
 tb/tb_simd_divider.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/simd_divider.sv
// -----------------------------------------------------------------------------
// simd_divider
//   Iterative SIMD unsigned restoring divider. One 16-bit, two 8-bit or four
//   4-bit lanes are divided in parallel, one quotient bit per lane per clock.
//   Same mode encoding and operand packing as the SIMD Booth multiplier.
//
// Optional feature macro: SIMD_DIV_SIGNED_EN (two's-complement lanes).
//
// Ports:
//   clk     in   1   clock, rising edge
//   clr     in   1   synchronous active-high reset
//   start   in   1   request a division (sampled only in IDLE)
//   mode    in   2   00: 1x16, 01: 2x8, 10: 4x4, 11: as 00 (captured with start)
//   Q       in  16   packed dividends
//   M       in  16   packed divisors
//   busy    out  1   high in RUN and DONE
//   done    out  1   one-cycle pulse, result/dz valid from this cycle on
//   result  out 32   [15:0] packed quotients, [31:16] packed remainders
//   dz      out  4   per-lane divide-by-zero flags (unused lanes 0)
// -----------------------------------------------------------------------------
module simd_divider (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] Q,
    input  logic [15:0] M,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [3:0]  dz
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int lane_w(input logic [1:0] md);
        case (md)
            2'b01:   return 8;
            2'b10:   return 4;
            default: return 16;
        endcase
    endfunction

    function automatic logic [15:0] lmask(input int w);
        return 16'((32'd1 << w) - 32'd1);
    endfunction

    state_t      state_q;
    logic [1:0]  mode_q;
    logic [4:0]  cnt_q;
    logic [15:0] rem_q;   // packed partial remainders
    logic [15:0] dvd_q;   // packed dividends, quotient bits shift in at the LSB
    logic [15:0] dvs_q;   // packed divisors
    logic [3:0]  dzc_q;   // divide-by-zero flags captured at start

    logic [15:0] q_cap, m_cap;
    logic [3:0]  dz_in;
    logic [15:0] rem_d, dvd_d;
    logic [31:0] res_d;

`ifdef SIMD_DIV_SIGNED_EN
    logic [3:0]  qneg_q, rneg_q;
    logic [3:0]  qneg_in, rneg_in;
`endif

    // ------------------------------------------------------------------
    // Capture: per-lane zero-divisor detection (and magnitude conversion
    // in signed builds), computed from the live inputs.
    // ------------------------------------------------------------------
    int          wc;
    logic [15:0] mkc, ca, cb;
`ifdef SIMD_DIV_SIGNED_EN
    logic        sa, sb;
`endif

    always_comb begin
        wc    = lane_w(mode);
        mkc   = lmask(wc);
        ca    = '0;
        cb    = '0;
        dz_in = '0;
`ifdef SIMD_DIV_SIGNED_EN
        sa      = 1'b0;
        sb      = 1'b0;
        q_cap   = '0;
        m_cap   = '0;
        qneg_in = '0;
        rneg_in = '0;
`else
        q_cap = Q;
        m_cap = M;
`endif
        for (int i = 0; i < 4; i++) begin
            if (i * wc < 16) begin
                ca       = (Q >> (i * wc)) & mkc;
                cb       = (M >> (i * wc)) & mkc;
                dz_in[i] = (cb == 16'd0);
`ifdef SIMD_DIV_SIGNED_EN
                sa = ca[4'(wc - 1)];
                sb = cb[4'(wc - 1)];
                // Most-negative stays at its own bit pattern, which read as
                // unsigned is exactly its magnitude.
                if (sa) ca = (~ca + 16'd1) & mkc;
                if (sb) cb = (~cb + 16'd1) & mkc;
                q_cap      = q_cap | 16'(ca << (i * wc));
                m_cap      = m_cap | 16'(cb << (i * wc));
                qneg_in[i] = sa ^ sb;
                rneg_in[i] = sa;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // One restoring step on every lane of the captured configuration.
    // Lanes are extracted, stepped in isolation and repacked, so no carry
    // or borrow can cross a lane boundary.
    // ------------------------------------------------------------------
    int          ws;
    logic [15:0] mks, lr, ld, ls, lrn, ldn;
    logic [16:0] sh;
    logic        qb;

    always_comb begin
        ws    = lane_w(mode_q);
        mks   = lmask(ws);
        rem_d = '0;
        dvd_d = '0;
        lr    = '0;
        ld    = '0;
        ls    = '0;
        lrn   = '0;
        ldn   = '0;
        sh    = '0;
        qb    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i * ws < 16) begin
                lr = (rem_q >> (i * ws)) & mks;
                ld = (dvd_q >> (i * ws)) & mks;
                ls = (dvs_q >> (i * ws)) & mks;
                // rem is one bit wider than the lane after the shift
                sh = {lr, 1'b0} | {16'd0, ld[4'(ws - 1)]};
                if (sh >= {1'b0, ls}) begin
                    lrn = 16'(sh - {1'b0, ls});
                    qb  = 1'b1;
                end else begin
                    lrn = sh[15:0];
                    qb  = 1'b0;
                end
                ldn   = ({ld[14:0], qb}) & mks;
                rem_d = rem_d | 16'((lrn & mks) << (i * ws));
                dvd_d = dvd_d | 16'(ldn << (i * ws));
            end
        end
    end

    // ------------------------------------------------------------------
    // Final packing of the last step's quotients/remainders. A zero divisor
    // already yields all-ones quotient and remainder = dividend from the
    // restoring recurrence; signed builds must keep the quotient unsigned.
    // ------------------------------------------------------------------
    logic [15:0] mkf, fq, fr;

    always_comb begin
        mkf   = lmask(ws);
        res_d = '0;
        fq    = '0;
        fr    = '0;
        for (int i = 0; i < 4; i++) begin
            if (i * ws < 16) begin
                fq = (dvd_d >> (i * ws)) & mkf;
                fr = (rem_d >> (i * ws)) & mkf;
`ifdef SIMD_DIV_SIGNED_EN
                if (dzc_q[i])       fq = mkf;
                else if (qneg_q[i]) fq = (~fq + 16'd1) & mkf;
                if (rneg_q[i])      fr = (~fr + 16'd1) & mkf;
`endif
                res_d[15:0]  = res_d[15:0]  | 16'(fq << (i * ws));
                res_d[31:16] = res_d[31:16] | 16'(fr << (i * ws));
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            dz      <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            dzc_q   <= '0;
`ifdef SIMD_DIV_SIGNED_EN
            qneg_q  <= '0;
            rneg_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy    <= 1'b1;
                        mode_q  <= mode;
                        cnt_q   <= 5'(lane_w(mode));
                        rem_q   <= '0;
                        dvd_q   <= q_cap;
                        dvs_q   <= m_cap;
                        dzc_q   <= dz_in;
`ifdef SIMD_DIV_SIGNED_EN
                        qneg_q  <= qneg_in;
                        rneg_q  <= rneg_in;
`endif
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                        result  <= res_d;
                        dz      <= dzc_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simd_divider.sv
// -----------------------------------------------------------------------------
// tb_simd_divider
//   Self-checking bench for simd_divider: directed cases with literal
//   expectations plus randomized traffic compared every cycle against a
//   behavioural model (plain integer division per lane, issue timing tracked
//   by edge numbers).
// -----------------------------------------------------------------------------
module tb_simd_divider;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] Q = '0;
    logic [15:0] M = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [3:0]  dz;

    simd_divider dut (
        .clk(clk), .clr(clr), .start(start), .mode(mode), .Q(Q), .M(M),
        .busy(busy), .done(done), .result(result), .dz(dz)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {dz, remainders, quotients} from plain per-lane arithmetic.
    function automatic logic [35:0] ref_div(input logic [1:0] md, input logic [15:0] a, input logic [15:0] b);
        int          w, nl, ua, ub, mk, qq, rr, sa, sb;
        logic [15:0] qo, ro;
        logic [3:0]  z;
        w  = (md == 2'b01) ? 8 : (md == 2'b10) ? 4 : 16;
        nl = 16 / w;
        mk = (1 << w) - 1;
        qo = '0; ro = '0; z = '0;
        for (int i = 0; i < nl; i++) begin
            ua = int'((a >> (i * w))) & mk;
            ub = int'((b >> (i * w))) & mk;
            if (ub == 0) begin
                qq = mk; rr = ua; z[i] = 1'b1;
            end else begin
`ifdef SIMD_DIV_SIGNED_EN
                sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
                sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
                qq = sa / sb;
                rr = sa % sb;
`else
                sa = 0; sb = 0;
                qq = ua / ub;
                rr = ua % ub;
`endif
            end
            qo = qo | 16'((qq & mk) << (i * w));
            ro = ro | 16'((rr & mk) << (i * w));
        end
        return {z, ro, qo};
    endfunction

    // ---------------------------- model -------------------------------
    int          edge_n = 0;
    bit          m_active = 0, m_prev = 0;
    int          done_edge = 0, idle_edge = 0;
    logic        m_busy = 0, m_done = 0;
    logic [31:0] m_res = '0;
    logic [3:0]  m_dz = '0;
    logic [35:0] pend = '0;

    always @(posedge clk) begin
        edge_n++;
        if (clr) begin
            m_active = 0; m_busy = 0; m_done = 0; m_res = '0; m_dz = '0;
        end else begin
            m_prev = m_active;
            if (m_active && edge_n == idle_edge) m_active = 0;
            if (!m_prev && start) begin
                m_active  = 1;
                done_edge = edge_n + ((mode == 2'b01) ? 8 : (mode == 2'b10) ? 4 : 16);
                idle_edge = done_edge + 1;
                pend      = ref_div(mode, Q, M);
            end
            m_done = m_active && (edge_n == done_edge);
            if (m_done) begin
                m_res = pend[31:0];
                m_dz  = pend[35:32];
            end
            m_busy = m_active;
        end
    end

    // -------------------------- compare -------------------------------
    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   {35'd0, busy}, {35'd0, m_busy});
            check("done",   {35'd0, done}, {35'd0, m_done});
            check("result", {4'd0, result}, {4'd0, m_res});
            check("dz",     {32'd0, dz},   {32'd0, m_dz});
        end
    end

    // -------------------------- stimulus ------------------------------
    task automatic directed(input string name, input logic [1:0] md, input logic [15:0] q,
                            input logic [15:0] m, input logic [31:0] er, input logic [3:0] ed,
                            input int lat);
        int k;
        bit seen;
        seen = 0;
        start = 1'b1; mode = md; Q = q; M = m;
        @(negedge clk);
        k = edge_n;
        start = 1'b0; mode = 2'($urandom); Q = 16'($urandom); M = 16'($urandom);
        for (int c = 0; c < 40; c++) begin
            if (done) begin seen = 1; break; end
            @(negedge clk);
        end
        if (!seen) begin
            check({name, "_timeout"}, 36'd0, 36'd1);
        end else begin
            check({name, "_lat"}, 36'(edge_n - k), 36'(lat));
            check({name, "_res"}, {4'd0, result}, {4'd0, er});
            check({name, "_dz"},  {32'd0, dz}, {32'd0, ed});
        end
        @(negedge clk);
    endtask

    int dn_cnt;

    initial begin
        // Pin the reference model itself with hand-computed values.
        check("pin1", ref_div(2'b00, 16'h03E8, 16'h0007), {4'b0000, 32'h0006008E});
        check("pin2", ref_div(2'b01, 16'hC864, 16'h0D07), {4'b0000, 32'h05020F0E});
        check("pin3", ref_div(2'b10, 16'hF931, 16'h2401), {4'b0010, 32'h113072F1});

        clr = 1'b1;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        clr = 1'b0;
        check("rst_busy", {35'd0, busy}, 36'd0);
        check("rst_res",  {4'd0, result}, 36'd0);
        @(negedge clk);

        directed("t1", 2'b00, 16'h03E8, 16'h0007, 32'h0006008E, 4'b0000, 16);
        directed("t2", 2'b01, 16'hC864, 16'h0D07, 32'h05020F0E, 4'b0000, 8);
        directed("t3", 2'b10, 16'hF931, 16'h2401, 32'h113072F1, 4'b0010, 4);
        directed("t3m11", 2'b11, 16'h0064, 16'h0000, 32'h0064FFFF, 4'b0001, 16);
`ifdef SIMD_DIV_SIGNED_EN
        directed("t5", 2'b01, 16'h809C, 16'hFF07, 32'h00FE80F2, 4'b0000, 8);
`else
        directed("t5", 2'b01, 16'h809C, 16'hFF07, 32'h80020016, 4'b0000, 8);
`endif

        // Second start during RUN is ignored: 0xFFFF / 0x10 = 0xFFF rem 0xF.
        start = 1'b1; mode = 2'b00; Q = 16'hFFFF; M = 16'h0010;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; mode = 2'b10; Q = 16'h1234; M = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        dn_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) begin
                dn_cnt++;
                check("t4_res", {4'd0, result}, {4'd0, 32'h000F0FFF});
            end
            @(negedge clk);
        end
        check("t4_ndone", 36'(dn_cnt), 36'd1);

        // Reset five cycles into an operation: aborted, no done afterwards.
        start = 1'b1; mode = 2'b00; Q = 16'h4321; M = 16'h0033;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t4_clr_busy", {35'd0, busy}, 36'd0);
        check("t4_clr_done", {35'd0, done}, 36'd0);
        check("t4_clr_res",  {4'd0, result}, 36'd0);
        dn_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            if (done) dn_cnt++;
            @(negedge clk);
        end
        check("t4_clr_nodone", 36'(dn_cnt), 36'd0);

        // Back-to-back mode-10 issues at the earliest legal edge, mode
        // scrambled between them (the model checks every done).
        dn_cnt = 0;
        for (int n = 0; n < 5; n++) begin
            start = 1'b1; mode = 2'b10; Q = 16'($urandom); M = 16'($urandom);
            @(negedge clk);
            start = 1'b0; mode = 2'($urandom);
            for (int c = 0; c < 5; c++) begin
                if (done) dn_cnt++;
                @(negedge clk);
            end
        end
        repeat (6) begin
            if (done) dn_cnt++;
            @(negedge clk);
        end
        check("t6_ndone", 36'(dn_cnt), 36'd5);

        // Random traffic: random starts (many ignored), zero divisor lanes,
        // rare resets.
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 2) == 0);
            mode  = 2'($urandom);
            Q     = 16'($urandom);
            M     = ($urandom_range(0, 3) == 0) ? 16'($urandom) & 16'($urandom) & 16'($urandom)
                                                : 16'($urandom);
            clr   = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        clr   = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
